// File: rtl/pulse_train_gen_pkg.sv
// rtl/pulse_train_gen_pkg.sv - shared types and defaults for the pulse-train generator
package pulse_train_gen_pkg;

    localparam int DEF_CNT_W = 16;
    localparam int DEF_WID_W = 8;

    localparam int DEF_NUM  = 0;
    localparam int DEF_HIGH = 1;
    localparam int DEF_LOW  = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } ch_state_e;

endpackage

// File: rtl/pulse_train_gen_ch.sv
// rtl/pulse_train_gen_ch.sv - one pulse-train channel: shadow config, working copy, FSM
module pulse_train_ch
    import pulse_train_gen_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W,
    parameter int WID_W = DEF_WID_W
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic             i_cfg_we,
    input  logic [CNT_W-1:0] i_cfg_num,
    input  logic [WID_W-1:0] i_cfg_high,
    input  logic [WID_W-1:0] i_cfg_low,
    input  logic             i_start,
    input  logic             i_abort,
    output logic             o_pulse,
    output logic             o_busy,
    output logic             o_done
);

    logic [CNT_W-1:0] r_num;
    logic [WID_W-1:0] r_high;
    logic [WID_W-1:0] r_low;
    logic [WID_W-1:0] r_work_high;
    logic [WID_W-1:0] r_work_low;
    logic [WID_W-1:0] r_timer;
    logic [CNT_W-1:0] r_rem;
    ch_state_e        r_state;
    logic             r_pulse;
    logic             r_busy;
    logic             r_done;

    logic [WID_W-1:0] w_high_eff;
    logic [WID_W-1:0] w_low_eff;

    // A zero width would swallow a phase; clamp to one cycle so every pulse has an edge.
    assign w_high_eff = (r_high == '0) ? WID_W'(1) : r_high;
    assign w_low_eff  = (r_low  == '0) ? WID_W'(1) : r_low;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_num       <= CNT_W'(DEF_NUM);
            r_high      <= WID_W'(DEF_HIGH);
            r_low       <= WID_W'(DEF_LOW);
            r_work_high <= WID_W'(DEF_HIGH);
            r_work_low  <= WID_W'(DEF_LOW);
            r_timer     <= '0;
            r_rem       <= '0;
            r_state     <= ST_IDLE;
            r_pulse     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            if (i_cfg_we) begin
                r_num  <= i_cfg_num;
                r_high <= i_cfg_high;
                r_low  <= i_cfg_low;
            end
            r_done <= 1'b0;
            if (i_abort) begin
                r_state <= ST_IDLE;
                r_pulse <= 1'b0;
                r_busy  <= 1'b0;
            end else if (i_en) begin
                case (r_state)
                    ST_IDLE: begin
                        if (i_start) begin
                            if (r_num == '0) begin
                                r_done <= 1'b1;
                            end else begin
                                r_work_high <= w_high_eff;
                                r_work_low  <= w_low_eff;
                                r_rem       <= r_num;
                                r_timer     <= w_high_eff;
                                r_state     <= ST_HIGH;
                                r_pulse     <= 1'b1;
                                r_busy      <= 1'b1;
                            end
                        end
                    end
                    ST_HIGH: begin
                        if (r_timer <= WID_W'(1)) begin
                            r_timer <= r_work_low;
                            r_state <= ST_LOW;
                            r_pulse <= 1'b0;
                        end else begin
                            r_timer <= r_timer - WID_W'(1);
                        end
                    end
                    ST_LOW: begin
                        if (r_timer <= WID_W'(1)) begin
                            r_rem <= r_rem - CNT_W'(1);
                            if (r_rem == CNT_W'(1)) begin
                                r_state <= ST_IDLE;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                            end else begin
                                r_timer <= r_work_high;
                                r_state <= ST_HIGH;
                                r_pulse <= 1'b1;
                            end
                        end else begin
                            r_timer <= r_timer - WID_W'(1);
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_pulse <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_pulse = r_pulse;
    assign o_busy  = r_busy;
    assign o_done  = r_done;

endmodule

// File: rtl/pulse_train_gen.sv
// rtl/pulse_train_gen.sv - sixteen-channel pulse-train generator top
module pulse_train_gen
    import pulse_train_gen_pkg::*;
#(
    parameter int NCH   = 16,
    parameter int CNT_W = DEF_CNT_W,
    parameter int WID_W = DEF_WID_W
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic             i_cfg_we,
    input  logic [3:0]       i_cfg_ch,
    input  logic [CNT_W-1:0] i_cfg_num,
    input  logic [WID_W-1:0] i_cfg_high,
    input  logic [WID_W-1:0] i_cfg_low,
    input  logic [NCH-1:0]   i_start,
    input  logic [NCH-1:0]   i_abort,
    output logic [NCH-1:0]   o_pulse,
    output logic [NCH-1:0]   o_busy,
    output logic [NCH-1:0]   o_done
);

    logic [NCH-1:0] w_cfg_we;

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        assign w_cfg_we[g] = i_cfg_we && (i_cfg_ch == 4'(g));

        pulse_train_ch #(
            .CNT_W (CNT_W),
            .WID_W (WID_W)
        ) u_ch (
            .i_clk      (i_clk),
            .i_rst_n    (i_rst_n),
            .i_en       (i_en),
            .i_cfg_we   (w_cfg_we[g]),
            .i_cfg_num  (i_cfg_num),
            .i_cfg_high (i_cfg_high),
            .i_cfg_low  (i_cfg_low),
            .i_start    (i_start[g]),
            .i_abort    (i_abort[g]),
            .o_pulse    (o_pulse[g]),
            .o_busy     (o_busy[g]),
            .o_done     (o_done[g])
        );
    end

endmodule

// File: tb/tb_pulse_train_gen.sv
// tb/tb_pulse_train_gen.sv - self-checking bench for pulse_train_gen
module tb_pulse_train_gen;

    localparam int NCH   = 16;
    localparam int CNT_W = 16;
    localparam int WID_W = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             en;
    logic             cfg_we;
    logic [3:0]       cfg_ch;
    logic [CNT_W-1:0] cfg_num;
    logic [WID_W-1:0] cfg_high;
    logic [WID_W-1:0] cfg_low;
    logic [NCH-1:0]   start;
    logic [NCH-1:0]   abort;
    logic [NCH-1:0]   pulse;
    logic [NCH-1:0]   busy;
    logic [NCH-1:0]   done;

    pulse_train_gen #(.NCH(NCH), .CNT_W(CNT_W), .WID_W(WID_W)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_en       (en),
        .i_cfg_we   (cfg_we),
        .i_cfg_ch   (cfg_ch),
        .i_cfg_num  (cfg_num),
        .i_cfg_high (cfg_high),
        .i_cfg_low  (cfg_low),
        .i_start    (start),
        .i_abort    (abort),
        .o_pulse    (pulse),
        .o_busy     (busy),
        .o_done     (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int ch;
        int num;
        int hi;
        int lo;
        int e_pulses;
        int e_high;
        int e_busy;
        int e_done;
    } vec_t;

    vec_t vecs[6];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cnt[NCH];
    int   dat[NCH];
    logic [NCH-1:0] prevv;
    int   pulses, high_cyc, busy_cyc, done_at, first_hw;
    logic prev, fell, busy_hold, done_seen, busy_seen;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input int ch, input int num, input int hi, input int lo);
        cfg_we   = 1'b1;
        cfg_ch   = 4'(ch);
        cfg_num  = CNT_W'(num);
        cfg_high = WID_W'(hi);
        cfg_low  = WID_W'(lo);
        tick;
        cfg_we   = 1'b0;
    endtask

    // One-cycle start, then observe until the done strobe or the budget runs out.
    task automatic watch(input int ch, input int budget, output int n_p, output int n_h,
                         output int n_b, output int d_at);
        logic pv;
        pv = 1'b0; n_p = 0; n_h = 0; n_b = 0; d_at = -1;
        start[ch] = 1'b1;
        tick;
        start[ch] = 1'b0;
        for (int c = 1; c <= budget; c++) begin
            if (pulse[ch] && !pv) n_p++;
            if (pulse[ch]) n_h++;
            if (busy[ch]) n_b++;
            pv = pulse[ch];
            if (done[ch]) begin
                d_at = c;
                break;
            end
            tick;
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{3, 5, 2, 3, 5, 10, 25, 26};
        vecs[1] = '{0, 0, 4, 4, 0, 0, 0, 1};
        vecs[2] = '{1, 3, 0, 0, 3, 3, 6, 7};
        vecs[3] = '{15, 1, 1, 1, 1, 1, 2, 3};
        vecs[4] = '{9, 2, 255, 1, 2, 510, 512, 513};
        vecs[5] = '{6, 4, 1, 5, 4, 4, 24, 25};

        rst_n = 1'b0; en = 1'b1; cfg_we = 1'b0; cfg_ch = '0; cfg_num = '0;
        cfg_high = '0; cfg_low = '0; start = '0; abort = '0;
        tick;
        tick;
        check("reset pulse", 32'(pulse), 0);
        check("reset busy", 32'(busy), 0);
        check("reset done", 32'(done), 0);
        rst_n = 1'b1;
        tick;

        for (int i = 0; i < 6; i++) begin
            cfg(vecs[i].ch, vecs[i].num, vecs[i].hi, vecs[i].lo);
            watch(vecs[i].ch, 600, pulses, high_cyc, busy_cyc, done_at);
            check($sformatf("vec%0d pulses", i), 32'(pulses), 32'(vecs[i].e_pulses));
            check($sformatf("vec%0d high cycles", i), 32'(high_cyc), 32'(vecs[i].e_high));
            check($sformatf("vec%0d busy cycles", i), 32'(busy_cyc), 32'(vecs[i].e_busy));
            check($sformatf("vec%0d done cycle", i), 32'(done_at), 32'(vecs[i].e_done));
            tick;
            check($sformatf("vec%0d done one cycle", i), 32'(done[vecs[i].ch]), 0);
        end

        // All channels together, num = i+1 at 1/1: done lands at 2*(i+1)+1.
        for (int i = 0; i < NCH; i++) cfg(i, i + 1, 1, 1);
        start = '1;
        tick;
        start = '0;
        prevv = '0;
        for (int i = 0; i < NCH; i++) begin
            cnt[i] = 0;
            dat[i] = -1;
        end
        for (int c = 1; c <= 40; c++) begin
            for (int i = 0; i < NCH; i++) begin
                if (pulse[i] && !prevv[i]) cnt[i]++;
                if (done[i] && dat[i] < 0) dat[i] = c;
            end
            prevv = pulse;
            tick;
        end
        for (int i = 0; i < NCH; i++) begin
            check($sformatf("all ch%0d pulses", i), 32'(cnt[i]), 32'(i + 1));
            check($sformatf("all ch%0d done cycle", i), 32'(dat[i]), 32'(2 * (i + 1) + 1));
        end

        // Freeze mid-HIGH for 7 cycles plus a config write during the train.
        cfg(5, 4, 4, 4);
        start[5] = 1'b1;
        tick;
        start[5] = 1'b0;
        prev = 1'b0; fell = 1'b0; pulses = 0; first_hw = 0; done_at = -1; busy_hold = 1'b1;
        for (int c = 1; c <= 80; c++) begin
            if (pulse[5] && !prev) pulses++;
            if (!fell && pulse[5]) first_hw++;
            if (prev && !pulse[5]) fell = 1'b1;
            if (c >= 3 && c <= 9 && !busy[5]) busy_hold = 1'b0;
            prev = pulse[5];
            if (done[5]) begin
                done_at = c;
                break;
            end
            en       = !(c >= 2 && c <= 8);
            cfg_we   = (c == 3);
            cfg_ch   = 4'd5;
            cfg_num  = 16'd9;
            cfg_high = 8'd4;
            cfg_low  = 8'd4;
            tick;
        end
        en = 1'b1;
        cfg_we = 1'b0;
        check("freeze pulses", 32'(pulses), 4);
        check("freeze first high width", 32'(first_hw), 11);
        check("freeze done cycle", 32'(done_at), 40);
        check("freeze busy held", 32'(busy_hold), 1);
        tick;
        watch(5, 200, pulses, high_cyc, busy_cyc, done_at);
        check("new cfg pulses", 32'(pulses), 9);
        check("new cfg done cycle", 32'(done_at), 73);
        tick;

        // Abort during the third pulse, with a simultaneous start.
        cfg(7, 10, 2, 2);
        start[7] = 1'b1;
        tick;
        start[7] = 1'b0;
        prev = 1'b0; pulses = 0;
        for (int c = 1; c <= 9; c++) begin
            if (pulse[7] && !prev) pulses++;
            prev = pulse[7];
            if (c < 9) tick;
        end
        check("abort pulses before", 32'(pulses), 3);
        check("abort pulse high before", 32'(pulse[7]), 1);
        abort[7] = 1'b1;
        start[7] = 1'b1;
        tick;
        abort[7] = 1'b0;
        start[7] = 1'b0;
        check("abort pulse", 32'(pulse[7]), 0);
        check("abort busy", 32'(busy[7]), 0);
        check("abort done", 32'(done[7]), 0);
        done_seen = 1'b0; busy_seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick;
            done_seen = done_seen | done[7];
            busy_seen = busy_seen | busy[7];
        end
        check("abort no later done", 32'(done_seen), 0);
        check("abort no later busy", 32'(busy_seen), 0);

        // Held start re-triggers right after done.
        cfg(10, 1, 1, 1);
        start[10] = 1'b1;
        tick;
        check("hold c1 pulse", 32'(pulse[10]), 1);
        tick;
        tick;
        check("hold c3 done", 32'(done[10]), 1);
        check("hold c3 busy", 32'(busy[10]), 0);
        tick;
        start[10] = 1'b0;
        check("hold c4 pulse", 32'(pulse[10]), 1);
        check("hold c4 busy", 32'(busy[10]), 1);
        tick;
        tick;
        tick;

        // Reset mid-train, then defaults give a bare done strobe.
        cfg(2, 6, 3, 3);
        cfg(4, 6, 3, 3);
        start = 16'h0014;
        tick;
        start = '0;
        tick;
        check("pre-reset pulse ch2", 32'(pulse[2]), 1);
        rst_n = 1'b0;
        tick;
        check("mid reset pulse", 32'(pulse), 0);
        check("mid reset busy", 32'(busy), 0);
        check("mid reset done", 32'(done), 0);
        rst_n = 1'b1;
        tick;
        watch(2, 10, pulses, high_cyc, busy_cyc, done_at);
        check("post reset pulses", 32'(pulses), 0);
        check("post reset busy", 32'(busy_cyc), 0);
        check("post reset done cycle", 32'(done_at), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
